// File: rtl/edge_sync_pkg.sv
// Shared helpers for the edge_sync_filter slice: counter sizing and parameter legality checks.
`ifndef EDGE_SYNC_PKG_SV
`define EDGE_SYNC_PKG_SV

`define EDGE_SYNC_SYNC_OK(S)   ((S) >= 2)
`define EDGE_SYNC_FILTER_OK(F) ((F) >= 1)

package edge_sync_pkg;

  // The counter only ever reaches FILTER_LEN-1, so $clog2(FILTER_LEN) bits suffice (min 1).
  function automatic int cntWidth(input int filter_len);
    int w;
    w = $clog2(filter_len);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

`endif

// File: rtl/edge_sync_chan.sv
// One channel: synchroniser chain, stability filter, registered level and edge pulses.
module edge_sync_chan
  import edge_sync_pkg::*;
#(
  parameter int   SYNC_STAGES = 2,
  parameter int   FILTER_LEN  = 1,
  parameter logic RESET_VAL   = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic in,
  output logic out,
  output logic rise,
  output logic fall
);

  localparam int            CW       = cntWidth(FILTER_LEN);
  localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_LEN - 1);

  (* ASYNC_REG = "TRUE" *) logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;
  logic                   syncd;

  logic          out_q, out_d;
  logic          rise_q, rise_d;
  logic          fall_q, fall_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], in};
  end

  assign syncd = sync_q[SYNC_STAGES-1];

  // A change is accepted only after FILTER_LEN consecutive enabled disagreeing samples.
  always_comb begin
    out_d  = out_q;
    cnt_d  = cnt_q;
    rise_d = 1'b0;
    fall_d = 1'b0;
    if (en) begin
      if (syncd == out_q) begin
        cnt_d = '0;
      end else if (cnt_q == CNT_LAST) begin
        out_d  = syncd;
        cnt_d  = '0;
        rise_d = syncd;
        fall_d = ~syncd;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= {SYNC_STAGES{RESET_VAL}};
      out_q  <= RESET_VAL;
      cnt_q  <= '0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      out_q  <= out_d;
      cnt_q  <= cnt_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign out  = out_q;
  assign rise = rise_q;
  assign fall = fall_q;

endmodule

// File: rtl/edge_sync_filter.sv
// Multi-channel async input conditioner: WIDTH independent sync/debounce/edge channels
// plus a combined any-edge indication.
module edge_sync_filter
  import edge_sync_pkg::*;
#(
  parameter int               WIDTH       = 1,
  parameter int               SYNC_STAGES = 2,
  parameter int               FILTER_LEN  = 1,
  parameter logic [WIDTH-1:0] RESET_VAL   = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic             anyEdge
);

  if (!`EDGE_SYNC_SYNC_OK(SYNC_STAGES)) begin : g_bad_sync
    $error("edge_sync_filter: SYNC_STAGES must be >= 2");
  end
  if (!`EDGE_SYNC_FILTER_OK(FILTER_LEN)) begin : g_bad_filter
    $error("edge_sync_filter: FILTER_LEN must be >= 1");
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_chan
    edge_sync_chan #(
      .SYNC_STAGES(SYNC_STAGES),
      .FILTER_LEN (FILTER_LEN),
      .RESET_VAL  (RESET_VAL[i])
    ) u_chan (
      .clk  (clk),
      .reset(reset),
      .en   (en),
      .in   (in[i]),
      .out  (out[i]),
      .rise (rise[i]),
      .fall (fall[i])
    );
  end

  // Combinational OR of flop outputs only, so it stays glitch-tolerant for downstream logic.
  assign anyEdge = |(rise | fall);

endmodule

// File: tb/tb_edge_sync_filter.sv
// Scoreboard bench: stimulus queues expected outputs per cycle, a negedge monitor checks them.
module tb_edge_sync_filter;

  logic       clk;
  logic       rstA, enA, rstB, enB;
  logic [3:0] inA, outA, riseA, fallA;
  logic [3:0] inB, outB, riseB, fallB;
  logic       anyA, anyB;
  int         cyc = 0;
  bit         done = 1'b0;
  int         total = 0;
  int         bad = 0;

  typedef struct {
    int         cyc;
    bit         b;
    logic [3:0] o;
    logic [3:0] r;
    logic [3:0] f;
    logic       a;
    string      nm;
  } exp_t;
  exp_t sb[$];

  // A: unfiltered, non-zero reset value. B: 4-sample debounce.
  edge_sync_filter #(.WIDTH(4), .SYNC_STAGES(2), .FILTER_LEN(1), .RESET_VAL(4'b1010)) dutA (
    .clk(clk), .reset(rstA), .en(enA), .in(inA),
    .out(outA), .rise(riseA), .fall(fallA), .anyEdge(anyA));

  edge_sync_filter #(.WIDTH(4), .SYNC_STAGES(2), .FILTER_LEN(4), .RESET_VAL(4'b0000)) dutB (
    .clk(clk), .reset(rstB), .en(enB), .in(inB),
    .out(outB), .rise(riseB), .fall(fallB), .anyEdge(anyB));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

  task automatic ex(input bit b, input int at, input logic [3:0] o, input logic [3:0] r,
                    input logic [3:0] f, input string nm);
    exp_t e;
    int   i;
    e.cyc = at; e.b = b; e.o = o; e.r = r; e.f = f; e.a = |(r | f); e.nm = nm;
    i = sb.size();
    while (i > 0 && sb[i-1].cyc > at) i--;
    sb.insert(i, e);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  // Monitor: checks every expectation due this cycle, away from the active edge.
  always @(negedge clk) begin
    exp_t       e;
    logic [3:0] go, gr, gf;
    logic       ga;
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      total++;
      if (e.cyc < cyc) begin
        bad++;
        $display("FAIL %s: expectation for cyc=%0d not checked (now %0d)", e.nm, e.cyc, cyc);
      end else begin
        go = e.b ? outB : outA;
        gr = e.b ? riseB : riseA;
        gf = e.b ? fallB : fallA;
        ga = e.b ? anyB : anyA;
        if (go !== e.o || gr !== e.r || gf !== e.f || ga !== e.a) begin
          bad++;
          $display("FAIL %s cyc=%0d dut=%s got out=%b rise=%b fall=%b any=%b want out=%b rise=%b fall=%b any=%b",
                   e.nm, cyc, e.b ? "B" : "A", go, gr, gf, ga, e.o, e.r, e.f, e.a);
        end
      end
    end
    if (done) begin
      total++;
      if (sb.size() != 0) begin
        bad++;
        $display("FAIL drain: %0d expectations left unchecked, want 0", sb.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
    end
  end

  initial begin
    int         c;
    logic [3:0] nin, h1, h2, mo, mr, mf;
    logic       nen;
    int         mc[4];

    rstA = 1'b1; rstB = 1'b1; enA = 1'b1; enB = 1'b1; inA = '0; inB = '0;
    @(posedge clk);
    #2;
    // Reset held for three edges
    c = cyc;
    for (int k = 0; k < 3; k++) begin
      ex(0, c + k, 4'b1010, 4'b0000, 4'b0000, "reset_A");
      ex(1, c + k, 4'b0000, 4'b0000, 4'b0000, "reset_B");
    end
    step(2);
    rstA = 1'b0; rstB = 1'b0;
    c = cyc;
    ex(0, c + 1, 4'b1010, 4'b0000, 4'b0000, "reset_exit_nopulse1");
    ex(0, c + 2, 4'b1010, 4'b0000, 4'b0000, "reset_exit_nopulse2");
    ex(0, c + 3, 4'b0000, 4'b0000, 4'b1010, "reset_exit_fall");
    ex(0, c + 4, 4'b0000, 4'b0000, 4'b0000, "reset_exit_quiet");
    step(5);

    // Basic latency, no filtering
    c = cyc; inA = 4'b0001;
    ex(0, c + 2, 4'b0000, 4'b0000, 4'b0000, "rise_early");
    ex(0, c + 3, 4'b0001, 4'b0001, 4'b0000, "rise_E3");
    ex(0, c + 4, 4'b0001, 4'b0000, 4'b0000, "rise_E4_clear");
    step(5);
    c = cyc; inA = 4'b0000;
    ex(0, c + 2, 4'b0001, 4'b0000, 4'b0000, "fall_early");
    ex(0, c + 3, 4'b0000, 4'b0000, 4'b0001, "fall_E3");
    ex(0, c + 4, 4'b0000, 4'b0000, 4'b0000, "fall_E4_clear");
    step(5);

    // Multi-channel simultaneous edges
    c = cyc; inA = 4'b0010;
    ex(0, c + 3, 4'b0010, 4'b0010, 4'b0000, "ch1_rise");
    step(5);
    c = cyc; inA = 4'b1011;
    ex(0, c + 3, 4'b1011, 4'b1001, 4'b0000, "ch0_ch3_rise");
    ex(0, c + 4, 4'b1011, 4'b0000, 4'b0000, "ch0_ch3_once");
    ex(0, c + 5, 4'b1001, 4'b0000, 4'b0010, "ch1_fall");
    ex(0, c + 6, 4'b1001, 4'b0000, 4'b0000, "ch1_fall_once");
    step(2);
    inA = 4'b1001;
    step(6);

    // Glitch rejection: 3-cycle pulse dropped
    c = cyc; inB = 4'b0001;
    for (int k = 1; k <= 8; k++) ex(1, c + k, 4'b0000, 4'b0000, 4'b0000, "glitch3_rejected");
    step(3);
    inB = 4'b0000;
    step(7);
    // 4-cycle pulse accepted
    c = cyc; inB = 4'b0001;
    ex(1, c + 5,  4'b0000, 4'b0000, 4'b0000, "pulse4_before");
    ex(1, c + 6,  4'b0001, 4'b0001, 4'b0000, "pulse4_rise_E6");
    ex(1, c + 7,  4'b0001, 4'b0000, 4'b0000, "pulse4_high1");
    ex(1, c + 8,  4'b0001, 4'b0000, 4'b0000, "pulse4_high2");
    ex(1, c + 9,  4'b0001, 4'b0000, 4'b0000, "pulse4_high3");
    ex(1, c + 10, 4'b0000, 4'b0000, 4'b0001, "pulse4_fall");
    ex(1, c + 11, 4'b0000, 4'b0000, 4'b0000, "pulse4_fall_once");
    step(4);
    inB = 4'b0000;
    step(10);

    // Enable gap holds the partial count
    c = cyc; inB = 4'b0001;
    for (int k = 1; k <= 10; k++) ex(1, c + k, 4'b0000, 4'b0000, 4'b0000, "en_hold");
    ex(1, c + 11, 4'b0001, 4'b0001, 4'b0000, "en_resume_rise");
    ex(1, c + 12, 4'b0001, 4'b0000, 4'b0000, "en_resume_once");
    step(4);
    enB = 1'b0;
    step(5);
    enB = 1'b1;
    step(5);

    // Reset mid-run discards cnt=3
    c = cyc; inB = 4'b0011;
    for (int k = 1; k <= 5; k++) ex(1, c + k, 4'b0001, 4'b0000, 4'b0000, "prereset_counting");
    for (int k = 6; k <= 11; k++) ex(1, c + k, 4'b0000, 4'b0000, 4'b0000, "postreset_fullrun");
    ex(1, c + 12, 4'b0011, 4'b0011, 4'b0000, "postreset_rise");
    ex(1, c + 13, 4'b0011, 4'b0000, 4'b0000, "postreset_once");
    step(5);
    rstB = 1'b1;
    step(1);
    rstB = 1'b0;
    step(8);

    // Random phase against a cycle model of dut B
    inB = 4'b0000;
    step(10);
    h1 = '0; h2 = '0; mo = '0;
    for (int k = 0; k < 4; k++) mc[k] = 0;
    for (int n = 0; n < 10000; n++) begin
      c = cyc;
      nin = inB;
      for (int k = 0; k < 4; k++) if ($urandom_range(5) == 0) nin[k] = ~nin[k];
      nen = ($urandom_range(7) != 0);
      inB = nin; enB = nen;
      mr = '0; mf = '0;
      if (nen) begin
        for (int k = 0; k < 4; k++) begin
          if (h2[k] == mo[k]) mc[k] = 0;
          else if (mc[k] == 3) begin
            mc[k] = 0; mo[k] = h2[k];
            if (h2[k]) mr[k] = 1'b1; else mf[k] = 1'b1;
          end else mc[k] = mc[k] + 1;
        end
      end
      ex(1, c + 1, mo, mr, mf, "random_model");
      h2 = h1; h1 = nin;
      step(1);
    end
    step(3);
    done = 1'b1;
  end

endmodule
